// File: rtl/rr_packet_arbiter_pkg.sv
// Shared definitions for the round-robin arbiters.
// Contents:
//   arb_state_t - arbiter FSM encoding (ARB_IDLE / ARB_LOCKED)
//   clog2       - constant-foldable ceiling log2, for deriving index widths
package rr_packet_arbiter_pkg;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Returns the number of bits needed to index n items (n >= 2).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_packet_arbiter_if.sv
// Request/grant bundle between the input buffers (master) and the arbiter
// (slave).
// Signals:
//   req_i         per-input request, N-hot
//   last_i        per-input tail-flit marker
//   ack_i         downstream accepted the granted flit
//   grant_o       one-hot grant or all-zero
//   grant_valid_o |grant_o
//   grant_idx_o   binary index of the granted input, 0 when no grant
//   lock_o        a packet currently holds the output
interface rr_packet_arbiter_if
  import rr_packet_arbiter_pkg::*;
#(
  parameter int IN_N  = 5,
  parameter int IDX_W = clog2(IN_N)
);

  logic [IN_N-1:0]  req_i;
  logic [IN_N-1:0]  last_i;
  logic             ack_i;
  logic [IN_N-1:0]  grant_o;
  logic             grant_valid_o;
  logic [IDX_W-1:0] grant_idx_o;
  logic             lock_o;

  modport master (
    output req_i, last_i, ack_i,
    input  grant_o, grant_valid_o, grant_idx_o, lock_o
  );

  modport slave (
    input  req_i, last_i, ack_i,
    output grant_o, grant_valid_o, grant_idx_o, lock_o
  );

endinterface

// File: rtl/rr_packet_arbiter_priority_select.sv
// rr_priority_select: combinational find-first-at-or-after-pointer.
// Ports:
//   req    in  IN_N   request vector
//   ptr    in  IDX_W  highest-priority index (< IN_N)
//   onehot out IN_N   one-hot winner, all-zero when req == 0
//   idx    out IDX_W  winner index, 0 when req == 0
//   valid  out 1      any request present
module rr_priority_select
  import rr_packet_arbiter_pkg::*;
#(
  parameter int IN_N  = 5,
  parameter int IDX_W = clog2(IN_N)
) (
  input  logic [IN_N-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IN_N-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IN_N-1:0] rot;
  int              off;
  int              idx_sum;

  always_comb begin
    // Doubling the vector lets a plain right shift act as a rotation, so
    // bit 0 of rot is req[ptr] and bit k is req[(ptr+k) mod IN_N].
    rot     = IN_N'({req, req} >> ptr);
    valid   = 1'b0;
    off     = 0;
    // Scan downward so the lowest set offset is the one left standing.
    for (int i = IN_N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        off   = i;
      end
    end
    idx_sum = int'(ptr) + off;
    if (idx_sum >= IN_N) idx_sum = idx_sum - IN_N;
    idx = valid ? IDX_W'(idx_sum) : '0;
  end

  for (genvar gi = 0; gi < IN_N; gi++) begin : g_onehot
    assign onehot[gi] = valid && (idx == IDX_W'(gi));
  end

endmodule

// File: rtl/rr_packet_arbiter.sv
// rr_packet_arbiter: work-conserving round-robin arbiter for a switch output
// port, with optional wormhole locking from head flit to tail flit.
// Ports:
//   clk_i  clock
//   rst_ni synchronous active-low reset
//   bus    rr_packet_arbiter_if.slave (req/last/ack in, grant/idx/lock out)
module rr_packet_arbiter
  import rr_packet_arbiter_pkg::*;
#(
  parameter int IN_N    = 5,
  parameter bit LOCK_EN = 1'b1,
  parameter int IDX_W   = clog2(IN_N)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  rr_packet_arbiter_if.slave   bus
);

  arb_state_t       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [IDX_W-1:0] owner_reg, owner_next;

  logic [IN_N-1:0]  sel_onehot;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_valid;
  logic [IN_N-1:0]  owner_onehot;

  logic [IN_N-1:0]  grant;
  logic             grant_valid;
  logic [IDX_W-1:0] grant_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(IN_N - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_priority_select #(
    .IN_N  (IN_N),
    .IDX_W (IDX_W)
  ) u_select (
    .req    (bus.req_i),
    .ptr    (ptr_reg),
    .onehot (sel_onehot),
    .idx    (sel_idx),
    .valid  (sel_valid)
  );

  for (genvar gi = 0; gi < IN_N; gi++) begin : g_owner
    assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
  end

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= ARB_IDLE;
      ptr_reg   <= '0;
      owner_reg <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      owner_reg <= owner_next;
    end
  end

  // Next-state logic; nothing moves unless a granted flit is acked.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    owner_next = owner_reg;
    if (grant_valid && bus.ack_i) begin
      if (state_reg == ARB_IDLE) begin
        if (!LOCK_EN || (|(bus.last_i & grant))) begin
          ptr_next = next_idx(grant_idx);
        end else begin
          state_next = ARB_LOCKED;
          owner_next = grant_idx;
        end
      end else if (|(bus.last_i & owner_onehot)) begin
        state_next = ARB_IDLE;
        ptr_next   = next_idx(owner_reg);
      end
    end
  end

  // Output logic; while locked, a missing owner request gives a bubble
  // rather than letting another input in.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    if (rst_ni) begin
      if (state_reg == ARB_IDLE) begin
        grant       = sel_onehot;
        grant_valid = sel_valid;
        grant_idx   = sel_idx;
      end else if (|(bus.req_i & owner_onehot)) begin
        grant       = owner_onehot;
        grant_valid = 1'b1;
        grant_idx   = owner_reg;
      end
    end
  end

  assign bus.grant_o       = grant;
  assign bus.grant_valid_o = grant_valid;
  assign bus.grant_idx_o   = grant_idx;
  assign bus.lock_o        = (state_reg == ARB_LOCKED);

endmodule

// File: doc/rr_packet_arbiter.md
Name: rr_packet_arbiter

Overview:
Parametrised, work-conserving round-robin arbiter for switch output ports.
- Always grants the first requesting input at or after a rotating priority pointer, so no cycle is lost on an idle high-priority input.
- Optionally locks the grant to one input from head flit to tail flit, so wormhole packets are never interleaved.
- Sits between the input buffers' request lines and the output crossbar select.

Parameters:
IN_N, 5, number of requesting inputs; legal range is IN_N >= 2.
LOCK_EN, 1, 1 = hold the grant until the tail flit (last_i) is acked; 0 = re-arbitrate after every acked flit.
IDX_W, $clog2(IN_N), width of the index outputs; derived, do not override.

Ports:
clk_i  input  1  clock.
rst_ni  input  1  synchronous active-low reset.
req_i  input  IN_N  per-input request, N-hot.
last_i  input  IN_N  per-input tail-flit marker; sampled only for the granted input.
ack_i  input  1  downstream accepted the granted flit this cycle.
grant_o  output  IN_N  one-hot grant, or all-zero; combinational.
grant_valid_o  output  1  equals |grant_o.
grant_idx_o  output  IDX_W  binary index of the granted input; 0 when grant_valid_o=0.
lock_o  output  1  registered; 1 while a packet holds the output.

Behaviour:
- Reset: one clock, synchronous, active-low (rst_ni=0 sampled on the clk_i rising edge).
  - State regs: ptr=0, owner=0, state=IDLE, lock_o=0.
  - While rst_ni=0, grant_o, grant_valid_o and grant_idx_o are forced to 0 regardless of req_i.
- Registers:
  - ptr (IDX_W): highest-priority index.
  - owner (IDX_W).
  - state: IDLE or LOCKED; lock_o = (state==LOCKED).
- Grant is combinational from the current state, with zero-cycle latency req -> grant.
- IDLE:
  - g = first i in cyclic order ptr, ptr+1, ..., ptr+IN_N-1 (mod IN_N) with req_i[i]=1.
  - grant_o = onehot(g); all-zero if req_i=0.
  - If the grant is nonzero and ack_i=1:
    - LOCK_EN=0, or last_i[g]=1: stay IDLE; ptr <= (g+1) mod IN_N.
    - Otherwise: go to LOCKED; owner <= g; ptr unchanged.
  - If the grant is nonzero and ack_i=0: no state or pointer change.
  - The grant may move to another input next cycle if req_i changes; the pointer advances only on an acked grant.
- LOCKED:
  - grant_o = onehot(owner) when req_i[owner]=1; otherwise all-zero (bubble, lock kept).
  - Requests from other inputs are ignored.
  - On ack_i=1 with req_i[owner]=1 and last_i[owner]=1: go to IDLE; ptr <= (owner+1) mod IN_N.
  - On ack_i=1 with last_i[owner]=0: stay LOCKED.
- ack_i while grant_o=0 is ignored in both states and changes no state.
- Wrap-around: the index after IN_N-1 is 0, including for non-power-of-two IN_N. Pointer values >= IN_N are unreachable.
- Single-flit packet (last_i=1 on the head flit): never enters LOCKED; identical to the LOCK_EN=0 path.
- Reset mid-packet: the lock is dropped with no flush. Upstream must also be reset.
- Fairness guarantee: with all inputs continuously requesting single-flit packets and ack_i=1, each input is granted exactly once every IN_N cycles.

Decomposition:
- Shared package/header: state encodings ARB_IDLE=1'b0 and ARB_LOCKED=1'b1, plus a clog2 helper function. Both are reused by future arbiters.
- One combinational sub-module, rr_priority_select:
  - Inputs: req (IN_N), ptr (IDX_W).
  - Outputs: onehot (IN_N), idx (IDX_W), valid.
  - Implementation: double-width request vector shifted by ptr, then a find-first search.
- The top level holds the FSM, ptr/owner registers and output muxing.

Test Plan:
1. IN_N=5, LOCK_EN=1, last_i=5'b11111, ack_i=1, req_i=5'b10100 held after reset -> grant_o 00100, 10000, 00100, 10000 on consecutive cycles; no empty cycle.
2. req_i=5'b00011; input 0 sends 3 flits with last_i[0]=1 on the 3rd; ack_i=1 -> grant_o=00001 for 3 cycles with lock_o=1 during the 2nd and 3rd cycles, then 00010 with ptr=1.
3. req_i=5'b00010, ack_i=0 for 4 cycles -> grant_o=00010 held each cycle, ptr stays 0, lock_o=0. Then ack_i=1 with last -> ptr=2.
4. Locked on input 3; req_i[3]=0 for 2 cycles while req_i[0]=1 -> grant_o=00000 and lock_o=1 for both cycles. req_i[3] returns -> grant_o=01000.
5. Locked on input 4 mid-packet; rst_ni=0 for one edge with req_i=11111 -> grant_o=0 while in reset. After release: lock_o=0, grant_o=00001.
6. LOCK_EN=0, req_i=5'b11111, last_i=0, ack_i=1 -> grant rotates 0,1,2,3,4,0; lock_o never asserts.
